adder_tree_pipe: RTL and testbench
==================================

// Module: adder_tree_pipe
// PURPOSE
// - Parametrised, fully pipelined binary adder tree: reduces NUM_IN operands of WIDTH bits to one full-precision sum.
// - Successor to the fixed 8-input tree. Adds generic width and input count, signed mode, a per-lane mask,
//   a valid/ready handshake with global stall, and a selectable early-tap output level.
// - Sits between operand producers (MAC arrays, accumulators) and downstream reduction or writeback logic.
// PARAMETERS
// - WIDTH     64  bits per input operand (>=1)
// - NUM_IN    8   number of input operands; power of two, >=2
// - SIGNED    0   1: operands and sums are two's complement (sign-extend per level); 0: unsigned (zero-extend)
// - TAP_LEVEL 0   number of top tree levels skipped. 0 gives the full sum; k>0 outputs the 2^k partial sums
//                 from level LEVELS-k.
// PORTS
// - clk        in   1                      rising-edge clock
// - rst_n      in   1                      asynchronous, active-low reset
// - in_valid   in   1                      operand vector valid
// - in_ready   out  1                      pipeline can accept this cycle
// - in_data    in   NUM_IN*WIDTH           operand i at [i*WIDTH +: WIDTH]
// - in_mask    in   NUM_IN                 1 = lane contributes; 0 = lane treated as zero
// - out_valid  out  1                      result valid
// - out_ready  in   1                      downstream accepts result
// - out_data   out  (2**TAP_LEVEL)*OW      OW = WIDTH+LEVELS-TAP_LEVEL; partial sum j at [j*OW +: OW]
// BEHAVIOUR
// - LEVELS = $clog2(NUM_IN). Stage 0 registers the masked operands. Stage L (1..LEVELS-TAP_LEVEL) registers
//   the pairwise sums of stage L-1.
// - Level-L sums are WIDTH+L bits. Each add extends both operands by 1 bit first, so no overflow or truncation
//   ever occurs. Sign extension is used if SIGNED=1, else zero extension.
// - Latency: result of a vector accepted at edge t is presented at edge t+LEVELS-TAP_LEVEL+1 when unstalled.
//   Throughput is 1 vector/clk.
// - Handshake: transfer on in_valid&&in_ready; result consumed on out_valid&&out_ready.
// - Global stall: stall = out_valid && !out_ready, and in_ready = !stall.
// - While stalled, every data and valid register holds its value. out_data and out_valid stay stable until
//   accepted.
// - The valid bit travels with the data through each stage. Bubbles are not collapsed; a stage whose valid bit
//   is 0 still loads, but its data is don't-care.
// - Masked lanes: operand replaced by 0 before stage 0; masks are sampled with in_data.
// - in_valid=0 with in_ready=1 inserts a bubble; out_valid=0 for that slot.
// - Reset (async assert, deassertion synchronised externally): all valid bits clear to 0 and out_valid=0.
//   out_data is 0 and all data registers are 0.
// - Reset mid-operation discards every in-flight vector; no partial result is ever emitted.
// - in_ready is 1 from the first cycle after reset release.
// - Simultaneous output accept and input accept in one cycle is legal; the pipeline advances by one.
// - A TAP_LEVEL>=LEVELS or a non-power-of-two NUM_IN is a configuration error: $error at elaboration.
// STRUCTURE
// - Package adder_tree_pkg holds:
//   - function tree_levels(n)
//   - function level_width(w,l)
//   - a localparam check macro for power-of-two
//   - typedef pipe_ctl_t {valid} shared with future reduction blocks.
// - Sub-module adder_tree_pipe_stage: one registered level.
//   - Params IN_W, N_PAIRS, SIGNED; ports clk, rst_n, en, in_valid, in_data, out_valid, out_data.
//   - en = !stall.
// - The top level is a generate loop over levels plus the stage-0 mask register and the stall/ready logic.
// TESTING
// - Reset then NUM_IN=8, WIDTH=64, unsigned, all mask=1, lanes = 1..8:
//   expect out_data = 36 with out_valid exactly 4 cycles after the accept.
// - Overflow: all 8 lanes = 64'hFFFF_FFFF_FFFF_FFFF, unsigned -> out_data = 67'h7_FFFF_FFFF_FFFF_FFF8, no truncation.
// - SIGNED=1, lanes = {-1,-1,-1,-1,-1,-1,-1,-1} -> out_data = 67-bit -8.
//   Then lanes {-5,3,0,0,0,0,0,0} -> -2.
// - Mask and tap: in_mask = 8'b0000_1111 with lanes 10,20,..,80 -> 100.
//   Separately, TAP_LEVEL=1 with lanes 1..8 -> partials {26, 10} (j=1, j=0).
// - Backpressure: stream 6 vectors back-to-back while out_ready is held low for 5 cycles mid-stream.
//   Expect in_ready to drop, out_data to stay stable while stalled, and all 6 sums to arrive in order,
//   none lost or duplicated.
// - Reset mid-stream: assert rst_n=0 with 3 vectors in flight. Expect out_valid=0 and out_data=0 immediately,
//   and no stale result after release.
//   Random vectors against a reference-model scoreboard for NUM_IN in {2,4,16}, WIDTH in {1,8,64}.

Source files
------------

// File: rtl/adder_tree_pkg.sv
// Shared definitions for the pipelined adder tree and future reduction blocks.
//   tree_levels(n)    : number of pairwise reduction levels for n operands
//   level_width(w, l) : operand width after l lossless pairwise additions
//   is_pow2(n)        : power-of-two test usable in constant expressions
//   pipe_ctl_t        : control word that travels alongside pipeline data
// No ports; this file only holds types, functions and a check macro.

`ifndef ADDER_TREE_IS_POW2
`define ADDER_TREE_IS_POW2(n) (((n) > 0) && ((((n) - 1) & (n)) == 0))
`endif

package adder_tree_pkg;

  typedef struct packed {
    logic valid;
  } pipe_ctl_t;

  function automatic int tree_levels(input int n);
    return $clog2(n);
  endfunction

  // Every pairwise add grows the result by exactly one bit.
  function automatic int level_width(input int w, input int l);
    return w + l;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && (((n - 1) & n) == 0);
  endfunction

endpackage

// File: rtl/adder_tree_pipe_stage.sv
// One registered level of the adder tree: adds N_PAIRS adjacent operand pairs
// of IN_W bits and registers the IN_W+1 bit sums together with the valid bit.
// Ports:
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   en          : advance enable (low while the pipeline is stalled)
//   in_valid    : valid bit of the previous level
//   in_data     : 2*N_PAIRS operands, operand k at [k*IN_W +: IN_W]
//   out_valid   : registered valid bit
//   out_data    : N_PAIRS sums, sum p at [p*(IN_W+1) +: IN_W+1]

module adder_tree_pipe_stage
  import adder_tree_pkg::*;
#(
  parameter int IN_W    = 8,
  parameter int N_PAIRS = 1,
  parameter bit SIGNED  = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic                                in_valid,
  input  logic [2*N_PAIRS*IN_W-1:0]           in_data,
  output logic                                out_valid,
  output logic [N_PAIRS*level_width(IN_W,1)-1:0] out_data
);

  localparam int OUT_W = level_width(IN_W, 1);

  // Widen by one bit before adding so the sum can never overflow.
  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] v);
    return {(SIGNED ? v[IN_W-1] : 1'b0), v};
  endfunction

  logic [N_PAIRS*OUT_W-1:0] sum_c;

  always_comb begin
    sum_c = '0;
    for (int p = 0; p < N_PAIRS; p++) begin
      sum_c[p*OUT_W +: OUT_W] = extend(in_data[(2*p)*IN_W +: IN_W])
                              + extend(in_data[(2*p+1)*IN_W +: IN_W]);
    end
  end

  // ---- level register: valid and data advance together, hold on stall ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= sum_c;
    end
  end

endmodule

// File: rtl/adder_tree_pipe.sv
// Fully pipelined binary adder tree. Reduces NUM_IN operands of WIDTH bits to
// full-precision sums, optionally stopping TAP_LEVEL levels short of the root
// to expose 2**TAP_LEVEL partial sums. One vector per clock; a single global
// stall freezes every stage while the output is held by the consumer.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   in_valid   : operand vector valid
//   in_ready   : pipeline accepts this cycle (low only while stalled)
//   in_data    : operand i at [i*WIDTH +: WIDTH]
//   in_mask    : 1 = lane contributes, 0 = lane forced to zero
//   out_valid  : result valid
//   out_ready  : consumer accepts result
//   out_data   : partial sum j at [j*OW +: OW], OW = WIDTH+LEVELS-TAP_LEVEL

module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int NUM_IN    = 8,
  parameter bit SIGNED    = 1'b0,
  parameter int TAP_LEVEL = 0,
  localparam int LEVELS   = tree_levels(NUM_IN),
  localparam int NSTG     = LEVELS - TAP_LEVEL,
  localparam int OW       = level_width(WIDTH, NSTG)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_IN*WIDTH-1:0]       in_data,
  input  logic [NUM_IN-1:0]             in_mask,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [(2**TAP_LEVEL)*OW-1:0]  out_data
);

  if (!(`ADDER_TREE_IS_POW2(NUM_IN)) || NUM_IN < 2) begin : g_bad_num_in
    $error("adder_tree_pipe: NUM_IN=%0d must be a power of two >= 2", NUM_IN);
  end
  if (TAP_LEVEL < 0 || TAP_LEVEL >= LEVELS) begin : g_bad_tap
    $error("adder_tree_pipe: TAP_LEVEL=%0d must lie in [0, %0d)", TAP_LEVEL, LEVELS);
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("adder_tree_pipe: WIDTH=%0d must be >= 1", WIDTH);
  end

  // A result sitting at the output that the consumer refuses freezes the
  // whole pipe; bubbles are not collapsed, so the stall is truly global.
  logic stall;
  logic en;

  assign stall    = out_valid && !out_ready;
  assign en       = !stall;
  assign in_ready = en;

  logic [NUM_IN*WIDTH-1:0] masked_c;

  always_comb begin
    masked_c = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      masked_c[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH] & {WIDTH{in_mask[i]}};
    end
  end

  // ---- stage 0: masked operands ----
  pipe_ctl_t               ctl_p0;
  logic [NUM_IN*WIDTH-1:0] data_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_p0  <= '0;
      data_p0 <= '0;
    end else if (en) begin
      ctl_p0.valid <= in_valid;
      data_p0      <= masked_c;
    end
  end

  // ---- stages 1..NSTG: pairwise sums of the previous stage ----
  for (genvar l = 1; l <= NSTG; l++) begin : g_lvl
    localparam int IN_W    = level_width(WIDTH, l - 1);
    localparam int N_PAIRS = NUM_IN >> l;

    logic [2*N_PAIRS*IN_W-1:0]     src_data;
    logic                          src_vld;
    logic                          vld;
    logic [N_PAIRS*(IN_W+1)-1:0]   sum;

    if (l == 1) begin : g_src
      assign src_data = data_p0;
      assign src_vld  = ctl_p0.valid;
    end else begin : g_src
      assign src_data = g_lvl[l-1].sum;
      assign src_vld  = g_lvl[l-1].vld;
    end

    adder_tree_pipe_stage #(
      .IN_W    (IN_W),
      .N_PAIRS (N_PAIRS),
      .SIGNED  (SIGNED)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (src_vld),
      .in_data   (src_data),
      .out_valid (vld),
      .out_data  (sum)
    );
  end

  if (NSTG >= 1) begin : g_out
    assign out_valid = g_lvl[NSTG].vld;
    assign out_data  = g_lvl[NSTG].sum;
  end else begin : g_out
    assign out_valid = 1'b0;
    assign out_data  = '0;
  end

endmodule

// File: tb/tb_adder_tree_pipe.sv
`timescale 1ns/1ps
module tb_adder_tree_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // A: 8 x 64 unsigned, full sum (OW 67)
  logic a_iv, a_ir, a_ov, a_or; logic [511:0] a_d; logic [7:0] a_m; logic [66:0] a_od;
  // S: 8 x 64 signed, full sum (OW 67)
  logic s_iv, s_ir, s_ov, s_or; logic [511:0] s_d; logic [7:0] s_m; logic [66:0] s_od;
  // T: 8 x 64 unsigned, TAP_LEVEL 1 (2 x 66)
  logic t_iv, t_ir, t_ov, t_or; logic [511:0] t_d; logic [7:0] t_m; logic [131:0] t_od;
  // R2: 2 x 1 signed (OW 2)
  logic r2_iv, r2_ir, r2_ov, r2_or; logic [1:0] r2_d; logic [1:0] r2_m; logic [1:0] r2_od;
  // R4: 4 x 8 unsigned (OW 10)
  logic r4_iv, r4_ir, r4_ov, r4_or; logic [31:0] r4_d; logic [3:0] r4_m; logic [9:0] r4_od;
  // R16: 16 x 64 signed (OW 68)
  logic r16_iv, r16_ir, r16_ov, r16_or; logic [1023:0] r16_d; logic [15:0] r16_m; logic [67:0] r16_od;

  adder_tree_pipe #(.WIDTH(64), .NUM_IN(8), .SIGNED(1'b0), .TAP_LEVEL(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d), .in_mask(a_m),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od));
  adder_tree_pipe #(.WIDTH(64), .NUM_IN(8), .SIGNED(1'b1), .TAP_LEVEL(0)) u_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_iv), .in_ready(s_ir), .in_data(s_d), .in_mask(s_m),
    .out_valid(s_ov), .out_ready(s_or), .out_data(s_od));
  adder_tree_pipe #(.WIDTH(64), .NUM_IN(8), .SIGNED(1'b0), .TAP_LEVEL(1)) u_t (
    .clk(clk), .rst_n(rst_n), .in_valid(t_iv), .in_ready(t_ir), .in_data(t_d), .in_mask(t_m),
    .out_valid(t_ov), .out_ready(t_or), .out_data(t_od));
  adder_tree_pipe #(.WIDTH(1), .NUM_IN(2), .SIGNED(1'b1), .TAP_LEVEL(0)) u_r2 (
    .clk(clk), .rst_n(rst_n), .in_valid(r2_iv), .in_ready(r2_ir), .in_data(r2_d), .in_mask(r2_m),
    .out_valid(r2_ov), .out_ready(r2_or), .out_data(r2_od));
  adder_tree_pipe #(.WIDTH(8), .NUM_IN(4), .SIGNED(1'b0), .TAP_LEVEL(0)) u_r4 (
    .clk(clk), .rst_n(rst_n), .in_valid(r4_iv), .in_ready(r4_ir), .in_data(r4_d), .in_mask(r4_m),
    .out_valid(r4_ov), .out_ready(r4_or), .out_data(r4_od));
  adder_tree_pipe #(.WIDTH(64), .NUM_IN(16), .SIGNED(1'b1), .TAP_LEVEL(0)) u_r16 (
    .clk(clk), .rst_n(rst_n), .in_valid(r16_iv), .in_ready(r16_ir), .in_data(r16_d), .in_mask(r16_m),
    .out_valid(r16_ov), .out_ready(r16_or), .out_data(r16_od));

  typedef struct {
    int             sel;   // 0 = A, 1 = S, 2 = T
    logic [511:0]   data;
    logic [7:0]     mask;
    logic [131:0]   exp;
    string          name;
  } vec_t;

  logic [127:0] qa[$], qs[$], q2[$], q4[$], q16[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pop_chk(input string nm, ref logic [127:0] q[$], input logic [255:0] act, input int ow);
    logic [255:0] e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got output %0h expected nothing (scoreboard empty)", nm, act);
    end else begin
      e = 256'(q.pop_front()) & ((256'd1 << ow) - 256'd1);
      chk(nm, act, e);
    end
  endtask

  // Reference: integer sum of the enabled lanes lo..lo+cnt-1, each lane read
  // as an unsigned or two's complement w-bit number, in 128-bit arithmetic.
  function automatic logic [127:0] ref_sum(input logic [1023:0] d, input logic [15:0] m,
                                           input int w, input bit sgn, input int lo, input int cnt);
    logic [127:0]  acc;
    logic [127:0]  v;
    logic [1023:0] lm;
    acc = '0;
    lm  = (1024'd1 << w) - 1024'd1;
    for (int i = lo; i < lo + cnt; i++) begin
      if (m[i]) begin
        v = 128'((d >> (i * w)) & lm);
        if (sgn && v[w-1]) v = v - (128'd1 << w);
        acc = acc + v;
      end
    end
    return acc;
  endfunction

  function automatic logic [511:0] seq8(input logic [63:0] base, input logic [63:0] step);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[i*64 +: 64] = base + 64'(i) * step;
    return r;
  endfunction

  function automatic logic [511:0] fill8(input logic [63:0] v);
    return {8{v}};
  endfunction

  function automatic logic [1023:0] rnd1024();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic cur_ov(input int sel);
    case (sel)
      0:       return a_ov;
      1:       return s_ov;
      default: return t_ov;
    endcase
  endfunction

  function automatic logic [131:0] cur_od(input int sel);
    case (sel)
      0:       return 132'(a_od);
      1:       return 132'(s_od);
      default: return t_od;
    endcase
  endfunction

  task automatic idle_all();
    a_iv = 0;  a_or = 1;  a_d = '0;  a_m = '1;
    s_iv = 0;  s_or = 1;  s_d = '0;  s_m = '1;
    t_iv = 0;  t_or = 1;  t_d = '0;  t_m = '1;
    r2_iv = 0; r2_or = 1; r2_d = '0; r2_m = '1;
    r4_iv = 0; r4_or = 1; r4_d = '0; r4_m = '1;
    r16_iv = 0; r16_or = 1; r16_d = '0; r16_m = '1;
  endtask

  // One vector through an otherwise idle pipe: checks latency and value.
  task automatic run_vec(input vec_t v);
    int n;
    int lat;
    lat = (v.sel == 2) ? 3 : 4;
    @(negedge clk);
    case (v.sel)
      0:       begin a_d = v.data; a_m = v.mask; a_iv = 1; end
      1:       begin s_d = v.data; s_m = v.mask; s_iv = 1; end
      default: begin t_d = v.data; t_m = v.mask; t_iv = 1; end
    endcase
    @(negedge clk);
    a_iv = 0; s_iv = 0; t_iv = 0;
    n = 1;
    while (!cur_ov(v.sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({v.name, "_latency"}, 256'(n), 256'(lat));
    chk(v.name, 256'(cur_od(v.sel)), 256'(v.exp));
    @(negedge clk);
  endtask

  vec_t         tbl[9];
  logic [511:0] vd[6];
  logic [127:0] e128;
  logic [66:0]  prev_od;
  bit           prev_stall, saw_block;
  int           sent, got, cyc, stale;

  initial begin
    rst_n = 1'b0;
    idle_all();

    tbl[0] = '{0, seq8(64'd1, 64'd1),   8'hFF, 132'd36, "sum_1_to_8"};
    tbl[1] = '{0, fill8('1),            8'hFF, 132'(67'h7_FFFF_FFFF_FFFF_FFF8), "unsigned_overflow"};
    tbl[2] = '{0, seq8(64'd10, 64'd10), 8'h0F, 132'd100, "mask_low4"};
    tbl[3] = '{0, seq8(64'd1, 64'd1),   8'h81, 132'd9,   "mask_ends"};
    tbl[4] = '{0, seq8(64'd1, 64'd1),   8'h00, 132'd0,   "mask_none"};
    tbl[5] = '{1, fill8('1),            8'hFF, 132'(67'h7_FFFF_FFFF_FFFF_FFF8), "signed_all_m1"};
    tbl[6] = '{1, {384'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB}, 8'hFF,
               132'(67'h7_FFFF_FFFF_FFFF_FFFE), "signed_m5_p3"};
    tbl[7] = '{1, fill8(64'h8000_0000_0000_0000), 8'hFF,
               132'(67'h4_0000_0000_0000_0000), "signed_most_negative"};
    tbl[8] = '{2, seq8(64'd1, 64'd1),   8'hFF, {66'd26, 66'd10}, "tap1_partials"};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("in_reset_out_valid", 256'(a_ov), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("after_reset_out_valid", 256'(a_ov), 256'(0));
    chk("after_reset_out_data", 256'(a_od), 256'(0));
    chk("after_reset_in_ready", 256'(a_ir), 256'(1));

    // Directed vectors
    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Backpressure: 6 vectors, out_ready low for 5 cycles mid-stream
    for (int i = 0; i < 6; i++) vd[i] = 512'(rnd1024());
    sent = 0; got = 0; cyc = 0; prev_stall = 0; saw_block = 0; prev_od = '0;
    while (got < 6 && cyc < 80) begin
      @(negedge clk);
      a_iv = (sent < 6);
      a_d  = vd[(sent < 6) ? sent : 0];
      a_m  = '1;
      a_or = !(cyc >= 5 && cyc < 10);
      #1;
      if (prev_stall) begin
        chk("bp_hold_data", 256'(a_od), 256'(prev_od));
        chk("bp_hold_valid", 256'(a_ov), 256'(1));
      end
      if (!a_ir) saw_block = 1;
      if (a_iv && a_ir) begin
        qa.push_back(ref_sum(1024'(vd[sent]), 16'hFFFF, 64, 1'b0, 0, 8));
        sent++;
      end
      if (a_ov && a_or) begin
        pop_chk("bp_in_order", qa, 256'(a_od), 67);
        got++;
      end
      prev_stall = a_ov && !a_or;
      prev_od    = a_od;
      cyc++;
    end
    chk("bp_results_received", 256'(got), 256'(6));
    chk("bp_in_ready_dropped", 256'(saw_block), 256'(1));
    chk("bp_leftover", 256'(qa.size()), 256'(0));
    idle_all();
    repeat (3) @(negedge clk);

    // Reset with one result at the output and three vectors in flight
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_iv = 1;
      a_d  = seq8(64'(i + 1), 64'd3);
    end
    @(negedge clk);
    a_iv = 0;
    #1;
    chk("rst_mid_precond_valid", 256'(a_ov), 256'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 256'(a_ov), 256'(0));
    chk("rst_mid_out_data", 256'(a_od), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (a_ov) stale++;
    end
    chk("rst_mid_no_stale_result", 256'(stale), 256'(0));
    chk("rst_mid_in_ready", 256'(a_ir), 256'(1));

    // Random traffic on all full-sum instances with a scoreboard each
    for (int c = 0; c < 460; c++) begin
      bit drain;
      @(negedge clk);
      drain = (c >= 400);
      a_iv   = !drain && ($urandom_range(0, 3) != 0); a_d  = 512'(rnd1024());
      a_m    = 8'($urandom);  a_or = drain || ($urandom_range(0, 3) != 0);
      s_iv   = !drain && ($urandom_range(0, 3) != 0); s_d  = 512'(rnd1024());
      s_m    = 8'($urandom);  s_or = drain || ($urandom_range(0, 3) != 0);
      r2_iv  = !drain && ($urandom_range(0, 3) != 0); r2_d = 2'($urandom);
      r2_m   = 2'($urandom);  r2_or = drain || ($urandom_range(0, 3) != 0);
      r4_iv  = !drain && ($urandom_range(0, 3) != 0); r4_d = 32'($urandom);
      r4_m   = 4'($urandom);  r4_or = drain || ($urandom_range(0, 3) != 0);
      r16_iv = !drain && ($urandom_range(0, 3) != 0); r16_d = rnd1024();
      r16_m  = 16'($urandom); r16_or = drain || ($urandom_range(0, 3) != 0);
      #1;
      if (a_iv && a_ir)     qa.push_back(ref_sum(1024'(a_d), 16'(a_m), 64, 1'b0, 0, 8));
      if (s_iv && s_ir)     qs.push_back(ref_sum(1024'(s_d), 16'(s_m), 64, 1'b1, 0, 8));
      if (r2_iv && r2_ir)   q2.push_back(ref_sum(1024'(r2_d), 16'(r2_m), 1, 1'b1, 0, 2));
      if (r4_iv && r4_ir)   q4.push_back(ref_sum(1024'(r4_d), 16'(r4_m), 8, 1'b0, 0, 4));
      if (r16_iv && r16_ir) q16.push_back(ref_sum(r16_d, r16_m, 64, 1'b1, 0, 16));
      if (a_ov && a_or)     pop_chk("rnd_n8_w64_u", qa, 256'(a_od), 67);
      if (s_ov && s_or)     pop_chk("rnd_n8_w64_s", qs, 256'(s_od), 67);
      if (r2_ov && r2_or)   pop_chk("rnd_n2_w1_s", q2, 256'(r2_od), 2);
      if (r4_ov && r4_or)   pop_chk("rnd_n4_w8_u", q4, 256'(r4_od), 10);
      if (r16_ov && r16_or) pop_chk("rnd_n16_w64_s", q16, 256'(r16_od), 68);
    end
    e128 = 128'(qa.size() + qs.size() + q2.size() + q4.size() + q16.size());
    chk("rnd_all_drained", 256'(e128), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
